// File: rtl/ebrick_umi_pkg.sv
// Shared UMI packet helpers for ebrick blocks.
// Packets pack MSB-first as {cmd, dstaddr, srcaddr, data}.
package ebrick_umi_pkg;

  localparam int UMI_MAXW = 256;

  typedef logic [UMI_MAXW-1:0] umi_word_t;

  function automatic int umi_pw(input int cw, input int aw, input int dw);
    return cw + 2 * aw + dw;
  endfunction

  function automatic umi_word_t umi_mask(input int w);
    return (umi_word_t'(1) << w) - umi_word_t'(1);
  endfunction

  function automatic umi_word_t umi_pack(
    input int        cw,
    input int        aw,
    input int        dw,
    input umi_word_t cmd,
    input umi_word_t dst,
    input umi_word_t src,
    input umi_word_t data
  );
    return ((cmd & umi_mask(cw)) << (2 * aw + dw))
         | ((dst & umi_mask(aw)) << (aw + dw))
         | ((src & umi_mask(aw)) << dw)
         | (data & umi_mask(dw));
  endfunction

  function automatic umi_word_t umi_field(
    input umi_word_t pkt,
    input int        lsb,
    input int        w
  );
    return (pkt >> lsb) & umi_mask(w);
  endfunction

endpackage

// File: rtl/ebrick_fifo_mem.sv
// Register-array storage for ebrick FIFOs.
// One write port, one asynchronous read port; contents never reset.
module ebrick_fifo_mem #(
  parameter     TARGET = "DEFAULT",
  parameter int DEPTH  = 4,
  parameter int PW     = 192
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [PW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [PW-1:0]            rdata
);

  if (TARGET == "DEFAULT") begin : g_generic
    logic [PW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
  end else begin : g_target
    // Hook for target-specific macros; same behaviour until one exists.
    logic [PW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
  end

endmodule

// File: rtl/ebrick_umi_port_fifo.sv
// Elastic first-word-fall-through UMI buffer for one crossbar uhost port.
// Ready depends only on registered occupancy, cutting the downstream ready path.
module ebrick_umi_port_fifo
  import ebrick_umi_pkg::*;
#(
  parameter     TARGET = "DEFAULT",
  parameter int CW     = 32,
  parameter int AW     = 64,
  parameter int DW     = 32,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   umi_in_valid,
  input  logic [CW-1:0]          umi_in_cmd,
  input  logic [AW-1:0]          umi_in_dstaddr,
  input  logic [AW-1:0]          umi_in_srcaddr,
  input  logic [DW-1:0]          umi_in_data,
  output logic                   umi_in_ready,
  output logic                   umi_out_valid,
  output logic [CW-1:0]          umi_out_cmd,
  output logic [AW-1:0]          umi_out_dstaddr,
  output logic [AW-1:0]          umi_out_srcaddr,
  output logic [DW-1:0]          umi_out_data,
  input  logic                   umi_out_ready,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int PW   = umi_pw(CW, AW, DW);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [CNTW-1:0] count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [PW-1:0]   wr_data;
  logic [PW-1:0]   rd_data;
  umi_word_t       rd_word;

  assign full  = (count == CNTW'(DEPTH));
  assign empty = (count == '0);

  assign umi_in_ready  = ~full & nreset;
  assign umi_out_valid = ~empty;
  assign fifo_count    = count;

  assign push = umi_in_valid & umi_in_ready;
  assign pop  = umi_out_valid & umi_out_ready;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign wr_data = PW'(umi_pack(CW, AW, DW,
                                umi_word_t'(umi_in_cmd),
                                umi_word_t'(umi_in_dstaddr),
                                umi_word_t'(umi_in_srcaddr),
                                umi_word_t'(umi_in_data)));

  ebrick_fifo_mem #(
    .TARGET (TARGET),
    .DEPTH  (DEPTH),
    .PW     (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign rd_word         = umi_word_t'(rd_data);
  assign umi_out_cmd     = CW'(umi_field(rd_word, 2 * AW + DW, CW));
  assign umi_out_dstaddr = AW'(umi_field(rd_word, AW + DW, AW));
  assign umi_out_srcaddr = AW'(umi_field(rd_word, DW, AW));
  assign umi_out_data    = DW'(umi_field(rd_word, 0, DW));

  a_no_push_full: assert property (
    @(posedge clk) disable iff (!nreset) !(push && full));
  a_no_pop_empty: assert property (
    @(posedge clk) disable iff (!nreset) !(pop && empty));
  a_count_max: assert property (
    @(posedge clk) disable iff (!nreset) count <= CNTW'(DEPTH));

endmodule
